// File: rtl/core_hcu_fwd.sv
// Hazard control unit: stall/flush sequencing for a 5-stage pipeline plus
// EX-stage operand forwarding selects and saturating stall/flush counters.
module core_hcu_fwd #(
    parameter int          RADDR_W = 5,
    parameter int unsigned FWD_EN  = 1,
    parameter int          CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               NRST,
    input  logic [RADDR_W-1:0] ID_RS1_ADDR,
    input  logic [RADDR_W-1:0] ID_RS2_ADDR,
    input  logic               ID_RS1_USED,
    input  logic               ID_RS2_USED,
    input  logic [RADDR_W-1:0] EX_RS1_ADDR,
    input  logic [RADDR_W-1:0] EX_RS2_ADDR,
    input  logic [RADDR_W-1:0] IDEX_RD_ADDR,
    input  logic [RADDR_W-1:0] EXMEM_RD_ADDR,
    input  logic [RADDR_W-1:0] MEMWB_RD_ADDR,
    input  logic               IDEX_RD_VALID,
    input  logic               EXMEM_RD_VALID,
    input  logic               MEMWB_RD_VALID,
    input  logic               IDEX_ISLOAD,
    input  logic               EXMEM_ISLOAD,
    input  logic               REDIRECT,
    input  logic               DMEM_REQ,
    input  logic               DMEM_DONE,
    input  logic               IMEM_BUSY,
    output logic               PC_WRITE,
    output logic               IFID_WRITE,
    output logic               IDEX_WRITE,
    output logic               EXMEM_WRITE,
    output logic               MEMWB_WRITE,
    output logic               IFID_FLUSH,
    output logic               IDEX_FLUSH,
    output logic               EXMEM_FLUSH,
    output logic [1:0]         FWD_A_SEL,
    output logic [1:0]         FWD_B_SEL,
    output logic [1:0]         HCU_STATE,
    output logic [CNT_W-1:0]   STALL_CNT,
    output logic [CNT_W-1:0]   FLUSH_CNT
);

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        DMEM_WAIT = 2'b01,
        KILL      = 2'b10
    } hcu_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hcu_state_t       state, state_next;
    logic             pc_w, ifid_w, idex_w, exmem_w, memwb_w;
    logic             ifid_f, idex_f, redirect_acc;
    logic             load_use, raw_nofwd, data_hazard, dmem_stall;
    logic             exmem_fwd_ok, memwb_fwd_ok;
    logic [1:0]       sel_a, sel_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    function automatic logic id_reads(input logic [RADDR_W-1:0] rd,
                                      input logic [RADDR_W-1:0] a1,
                                      input logic [RADDR_W-1:0] a2,
                                      input logic u1,
                                      input logic u2);
        return (rd != '0) && ((u1 && (a1 == rd)) || (u2 && (a2 == rd)));
    endfunction

    assign load_use = IDEX_ISLOAD && IDEX_RD_VALID &&
        id_reads(IDEX_RD_ADDR, ID_RS1_ADDR, ID_RS2_ADDR, ID_RS1_USED, ID_RS2_USED);

    // Without forwarding, any in-flight producer of an ID source must drain first.
    assign raw_nofwd = (FWD_EN == 0) && (
        (IDEX_RD_VALID  && id_reads(IDEX_RD_ADDR,  ID_RS1_ADDR, ID_RS2_ADDR, ID_RS1_USED, ID_RS2_USED)) ||
        (EXMEM_RD_VALID && id_reads(EXMEM_RD_ADDR, ID_RS1_ADDR, ID_RS2_ADDR, ID_RS1_USED, ID_RS2_USED)) ||
        (MEMWB_RD_VALID && id_reads(MEMWB_RD_ADDR, ID_RS1_ADDR, ID_RS2_ADDR, ID_RS1_USED, ID_RS2_USED)));

    assign data_hazard = load_use || raw_nofwd;
    assign dmem_stall  = DMEM_REQ && !DMEM_DONE;

    assign exmem_fwd_ok = EXMEM_RD_VALID && !EXMEM_ISLOAD && (EXMEM_RD_ADDR != '0);
    assign memwb_fwd_ok = MEMWB_RD_VALID && (MEMWB_RD_ADDR != '0);

    assign sel_a = (FWD_EN == 0)                                   ? 2'b00 :
                   (exmem_fwd_ok && (EXMEM_RD_ADDR == EX_RS1_ADDR)) ? 2'b01 :
                   (memwb_fwd_ok && (MEMWB_RD_ADDR == EX_RS1_ADDR)) ? 2'b10 : 2'b00;
    assign sel_b = (FWD_EN == 0)                                   ? 2'b00 :
                   (exmem_fwd_ok && (EXMEM_RD_ADDR == EX_RS2_ADDR)) ? 2'b01 :
                   (memwb_fwd_ok && (MEMWB_RD_ADDR == EX_RS2_ADDR)) ? 2'b10 : 2'b00;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) state <= RUN;
        else       state <= state_next;
    end

    // Next state and stage controls; a pending data access freezes everything.
    always_comb begin
        state_next   = state;
        pc_w         = 1'b1;
        ifid_w       = 1'b1;
        idex_w       = 1'b1;
        exmem_w      = 1'b1;
        memwb_w      = 1'b1;
        ifid_f       = 1'b0;
        idex_f       = 1'b0;
        redirect_acc = 1'b0;
        case (state)
            DMEM_WAIT: begin
                if (!DMEM_DONE) begin
                    {pc_w, ifid_w, idex_w, exmem_w, memwb_w} = 5'b0;
                end else begin
                    state_next = RUN;
                end
            end
            KILL: begin
                if (dmem_stall) begin
                    {pc_w, ifid_w, idex_w, exmem_w, memwb_w} = 5'b0;
                end else begin
                    ifid_f = 1'b1;
                    if (REDIRECT) begin
                        idex_f       = 1'b1;
                        redirect_acc = 1'b1;
                    end else if (!IMEM_BUSY) begin
                        state_next = RUN;
                    end
                end
            end
            default: begin
                state_next = RUN;
                if (dmem_stall) begin
                    {pc_w, ifid_w, idex_w, exmem_w, memwb_w} = 5'b0;
                    state_next = DMEM_WAIT;
                end else if (REDIRECT) begin
                    ifid_f       = 1'b1;
                    idex_f       = 1'b1;
                    redirect_acc = 1'b1;
                    if (IMEM_BUSY) state_next = KILL;
                end else if (data_hazard) begin
                    pc_w   = 1'b0;
                    ifid_w = 1'b0;
                    idex_f = 1'b1;
                end else if (IMEM_BUSY) begin
                    pc_w   = 1'b0;
                    ifid_w = 1'b0;
                    idex_w = 1'b0;
                    idex_f = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_w && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect_acc && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    // Reset must quiet every control output immediately, not at the next edge.
    assign PC_WRITE    = NRST & pc_w;
    assign IFID_WRITE  = NRST & ifid_w;
    assign IDEX_WRITE  = NRST & idex_w;
    assign EXMEM_WRITE = NRST & exmem_w;
    assign MEMWB_WRITE = NRST & memwb_w;
    assign IFID_FLUSH  = NRST & ifid_f;
    assign IDEX_FLUSH  = NRST & idex_f;
    assign EXMEM_FLUSH = 1'b0;
    assign FWD_A_SEL   = NRST ? sel_a : 2'b00;
    assign FWD_B_SEL   = NRST ? sel_b : 2'b00;
    assign HCU_STATE   = state;
    assign STALL_CNT   = stall_cnt;
    assign FLUSH_CNT   = flush_cnt;

endmodule

// File: tb/tb_core_hcu_fwd.sv
// Directed bench for core_hcu_fwd: a default instance and a no-forwarding,
// 2-bit-counter instance share one stimulus set.
module tb_core_hcu_fwd;
    localparam int RW = 5;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic [RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, idex_rd, exmem_rd, memwb_rd;
    logic id_rs1_used, id_rs2_used, idex_rd_valid, exmem_rd_valid, memwb_rd_valid;
    logic idex_isload, exmem_isload, redirect, dmem_req, dmem_done, imem_busy;

    logic pc_write, ifid_write, idex_write, exmem_write, memwb_write;
    logic ifid_flush, idex_flush, exmem_flush;
    logic [1:0] fwd_a_sel, fwd_b_sel, hcu_state;
    logic [15:0] stall_cnt, flush_cnt;

    logic a_pc_write, a_ifid_write, a_idex_write, a_exmem_write, a_memwb_write;
    logic a_ifid_flush, a_idex_flush, a_exmem_flush;
    logic [1:0] a_fwd_a_sel, a_fwd_b_sel, a_hcu_state;
    logic [1:0] a_stall_cnt, a_flush_cnt;

    int errors = 0;
    int checks = 0;

    core_hcu_fwd #(.RADDR_W(RW), .FWD_EN(1), .CNT_W(16)) u_dut (
        .CLK(clk), .NRST(nrst),
        .ID_RS1_ADDR(id_rs1), .ID_RS2_ADDR(id_rs2),
        .ID_RS1_USED(id_rs1_used), .ID_RS2_USED(id_rs2_used),
        .EX_RS1_ADDR(ex_rs1), .EX_RS2_ADDR(ex_rs2),
        .IDEX_RD_ADDR(idex_rd), .EXMEM_RD_ADDR(exmem_rd), .MEMWB_RD_ADDR(memwb_rd),
        .IDEX_RD_VALID(idex_rd_valid), .EXMEM_RD_VALID(exmem_rd_valid), .MEMWB_RD_VALID(memwb_rd_valid),
        .IDEX_ISLOAD(idex_isload), .EXMEM_ISLOAD(exmem_isload),
        .REDIRECT(redirect), .DMEM_REQ(dmem_req), .DMEM_DONE(dmem_done), .IMEM_BUSY(imem_busy),
        .PC_WRITE(pc_write), .IFID_WRITE(ifid_write), .IDEX_WRITE(idex_write),
        .EXMEM_WRITE(exmem_write), .MEMWB_WRITE(memwb_write),
        .IFID_FLUSH(ifid_flush), .IDEX_FLUSH(idex_flush), .EXMEM_FLUSH(exmem_flush),
        .FWD_A_SEL(fwd_a_sel), .FWD_B_SEL(fwd_b_sel), .HCU_STATE(hcu_state),
        .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt)
    );

    core_hcu_fwd #(.RADDR_W(RW), .FWD_EN(0), .CNT_W(2)) u_alt (
        .CLK(clk), .NRST(nrst),
        .ID_RS1_ADDR(id_rs1), .ID_RS2_ADDR(id_rs2),
        .ID_RS1_USED(id_rs1_used), .ID_RS2_USED(id_rs2_used),
        .EX_RS1_ADDR(ex_rs1), .EX_RS2_ADDR(ex_rs2),
        .IDEX_RD_ADDR(idex_rd), .EXMEM_RD_ADDR(exmem_rd), .MEMWB_RD_ADDR(memwb_rd),
        .IDEX_RD_VALID(idex_rd_valid), .EXMEM_RD_VALID(exmem_rd_valid), .MEMWB_RD_VALID(memwb_rd_valid),
        .IDEX_ISLOAD(idex_isload), .EXMEM_ISLOAD(exmem_isload),
        .REDIRECT(redirect), .DMEM_REQ(dmem_req), .DMEM_DONE(dmem_done), .IMEM_BUSY(imem_busy),
        .PC_WRITE(a_pc_write), .IFID_WRITE(a_ifid_write), .IDEX_WRITE(a_idex_write),
        .EXMEM_WRITE(a_exmem_write), .MEMWB_WRITE(a_memwb_write),
        .IFID_FLUSH(a_ifid_flush), .IDEX_FLUSH(a_idex_flush), .EXMEM_FLUSH(a_exmem_flush),
        .FWD_A_SEL(a_fwd_a_sel), .FWD_B_SEL(a_fwd_b_sel), .HCU_STATE(a_hcu_state),
        .STALL_CNT(a_stall_cnt), .FLUSH_CNT(a_flush_cnt)
    );

    task automatic idle_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0;
        idex_rd = '0; exmem_rd = '0; memwb_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        idex_rd_valid = 1'b0; exmem_rd_valid = 1'b0; memwb_rd_valid = 1'b0;
        idex_isload = 1'b0; exmem_isload = 1'b0;
        redirect = 1'b0; dmem_req = 1'b0; dmem_done = 1'b0; imem_busy = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        dmem_req = 1'b1; exmem_rd = 5'd7; exmem_rd_valid = 1'b1; ex_rs1 = 5'd7;
        #12;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_pc_write got=%0b exp=0", pc_write); end
        checks++; if (memwb_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_memwb_write got=%0b exp=0", memwb_write); end
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("[TB] FAIL reset_fwd_a got=%0b exp=00", fwd_a_sel); end
        checks++; if (hcu_state !== 2'b00) begin errors++; $display("[TB] FAIL reset_state got=%0b exp=00", hcu_state); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        idle_inputs();
        @(negedge clk);
        nrst = 1'b1;
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("[TB] FAIL release_pc_write got=%0b exp=1", pc_write); end
        tick();
    endtask

    task automatic test_load_use();
        idle_inputs();
        idex_isload = 1'b1; idex_rd_valid = 1'b1; idex_rd = 5'd5;
        id_rs1 = 5'd5; id_rs1_used = 1'b1; id_rs2 = 5'd6; id_rs2_used = 1'b1;
        @(negedge clk);
        checks++; if (pc_write !== 1'b0) begin errors++; $display("[TB] FAIL lu_pc_write got=%0b exp=0", pc_write); end
        checks++; if (ifid_write !== 1'b0) begin errors++; $display("[TB] FAIL lu_ifid_write got=%0b exp=0", ifid_write); end
        checks++; if (idex_flush !== 1'b1) begin errors++; $display("[TB] FAIL lu_idex_flush got=%0b exp=1", idex_flush); end
        tick();
        idle_inputs();
        exmem_rd = 5'd5; exmem_rd_valid = 1'b1; exmem_isload = 1'b1;
        id_rs1 = 5'd5; id_rs1_used = 1'b1; ex_rs1 = 5'd5;
        @(negedge clk);
        checks++; if (pc_write !== 1'b1) begin errors++; $display("[TB] FAIL lu_resume_pc got=%0b exp=1", pc_write); end
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("[TB] FAIL lu_no_fwd_load got=%0b exp=00", fwd_a_sel); end
        tick();
        idle_inputs();
        memwb_rd = 5'd5; memwb_rd_valid = 1'b1; ex_rs1 = 5'd5;
        @(negedge clk);
        checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("[TB] FAIL lu_fwd_a got=%0b exp=10", fwd_a_sel); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("[TB] FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
        tick();
    endtask

    task automatic test_dmem_wait();
        idle_inputs();
        dmem_req = 1'b1; redirect = 1'b1;
        @(negedge clk);
        checks++; if (pc_write !== 1'b0 || memwb_write !== 1'b0) begin errors++; $display("[TB] FAIL dm_c1_writes got=%0b%0b exp=00", pc_write, memwb_write); end
        checks++; if (ifid_flush !== 1'b0) begin errors++; $display("[TB] FAIL dm_c1_redirect_ignored got=%0b exp=0", ifid_flush); end
        tick();
        @(negedge clk);
        checks++; if (hcu_state !== 2'b01) begin errors++; $display("[TB] FAIL dm_c2_state got=%0b exp=01", hcu_state); end
        checks++; if (exmem_write !== 1'b0 || idex_flush !== 1'b0) begin errors++; $display("[TB] FAIL dm_c2_frozen got=%0b%0b exp=00", exmem_write, idex_flush); end
        tick();
        redirect = 1'b0; dmem_done = 1'b1;
        @(negedge clk);
        checks++; if (hcu_state !== 2'b01) begin errors++; $display("[TB] FAIL dm_c3_state got=%0b exp=01", hcu_state); end
        checks++; if (pc_write !== 1'b1 || memwb_write !== 1'b1) begin errors++; $display("[TB] FAIL dm_c3_release got=%0b%0b exp=11", pc_write, memwb_write); end
        tick();
        idle_inputs();
        dmem_req = 1'b1; dmem_done = 1'b1;
        @(negedge clk);
        checks++; if (hcu_state !== 2'b00) begin errors++; $display("[TB] FAIL dm_back_run got=%0b exp=00", hcu_state); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("[TB] FAIL dm_zero_wait got=%0b exp=1", pc_write); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (hcu_state !== 2'b00) begin errors++; $display("[TB] FAIL dm_zero_wait_state got=%0b exp=00", hcu_state); end
        checks++; if (stall_cnt !== 16'd3 || flush_cnt !== 16'd0) begin errors++; $display("[TB] FAIL dm_counters got=%0d/%0d exp=3/0", stall_cnt, flush_cnt); end
        tick();
    endtask

    task automatic test_redirect_kill();
        idle_inputs();
        redirect = 1'b1; imem_busy = 1'b1;
        @(negedge clk);
        checks++; if (ifid_flush !== 1'b1 || idex_flush !== 1'b1) begin errors++; $display("[TB] FAIL rd_c1_flush got=%0b%0b exp=11", ifid_flush, idex_flush); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("[TB] FAIL rd_c1_pc got=%0b exp=1", pc_write); end
        tick();
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (hcu_state !== 2'b10 || ifid_flush !== 1'b1) begin errors++; $display("[TB] FAIL rd_c2_kill got=%0b/%0b exp=10/1", hcu_state, ifid_flush); end
        checks++; if (pc_write !== 1'b1 || idex_flush !== 1'b0) begin errors++; $display("[TB] FAIL rd_c2_ctl got=%0b%0b exp=10", pc_write, idex_flush); end
        tick();
        imem_busy = 1'b0;
        @(negedge clk);
        checks++; if (hcu_state !== 2'b10 || ifid_flush !== 1'b1) begin errors++; $display("[TB] FAIL rd_c3_kill got=%0b/%0b exp=10/1", hcu_state, ifid_flush); end
        tick();
        @(negedge clk);
        checks++; if (hcu_state !== 2'b00 || ifid_flush !== 1'b0) begin errors++; $display("[TB] FAIL rd_c4_run got=%0b/%0b exp=00/0", hcu_state, ifid_flush); end
        checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd3) begin errors++; $display("[TB] FAIL rd_counters got=%0d/%0d exp=1/3", flush_cnt, stall_cnt); end
        tick();
    endtask

    task automatic test_back_to_back_redirect();
        idle_inputs();
        redirect = 1'b1; imem_busy = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (hcu_state !== 2'b10 || idex_flush !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second got=%0b/%0b exp=10/1", hcu_state, idex_flush); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (hcu_state !== 2'b10 || ifid_flush !== 1'b1) begin errors++; $display("[TB] FAIL b2b_stay_kill got=%0b/%0b exp=10/1", hcu_state, ifid_flush); end
        tick();
        @(negedge clk);
        checks++; if (hcu_state !== 2'b00 || flush_cnt !== 16'd3) begin errors++; $display("[TB] FAIL b2b_exit got=%0b/%0d exp=00/3", hcu_state, flush_cnt); end
        tick();
    endtask

    task automatic test_forwarding();
        idle_inputs();
        exmem_rd = 5'd7; exmem_rd_valid = 1'b1; memwb_rd = 5'd7; memwb_rd_valid = 1'b1;
        ex_rs1 = 5'd7; ex_rs2 = 5'd7;
        #2;
        checks++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01) begin errors++; $display("[TB] FAIL fwd_exmem_prio got=%0b/%0b exp=01/01", fwd_a_sel, fwd_b_sel); end
        exmem_rd = 5'd0; memwb_rd = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        #2;
        checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin errors++; $display("[TB] FAIL fwd_x0 got=%0b/%0b exp=00/00", fwd_a_sel, fwd_b_sel); end
        exmem_rd = 5'd7; exmem_isload = 1'b1; memwb_rd = 5'd7; ex_rs1 = 5'd7; ex_rs2 = 5'd9;
        #2;
        checks++; if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00) begin errors++; $display("[TB] FAIL fwd_load_skip got=%0b/%0b exp=10/00", fwd_a_sel, fwd_b_sel); end
        idle_inputs();
        tick();
    endtask

    task automatic test_priority();
        idle_inputs();
        idex_isload = 1'b1; idex_rd_valid = 1'b1; idex_rd = 5'd4;
        id_rs2 = 5'd4; id_rs2_used = 1'b1; imem_busy = 1'b1;
        @(negedge clk);
        checks++; if (pc_write !== 1'b0 || idex_write !== 1'b1 || idex_flush !== 1'b1) begin errors++; $display("[TB] FAIL pri_hazard_over_imem got=%0b%0b%0b exp=011", pc_write, idex_write, idex_flush); end
        tick();
        idle_inputs();
        imem_busy = 1'b1;
        @(negedge clk);
        checks++; if (idex_write !== 1'b0 || ifid_write !== 1'b0 || idex_flush !== 1'b1) begin errors++; $display("[TB] FAIL pri_imem_busy got=%0b%0b%0b exp=001", idex_write, ifid_write, idex_flush); end
        tick();
        idle_inputs();
        redirect = 1'b1; idex_isload = 1'b1; idex_rd_valid = 1'b1; idex_rd = 5'd4;
        id_rs2 = 5'd4; id_rs2_used = 1'b1;
        @(negedge clk);
        checks++; if (pc_write !== 1'b1 || ifid_flush !== 1'b1) begin errors++; $display("[TB] FAIL pri_redirect_over_hazard got=%0b%0b exp=11", pc_write, ifid_flush); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (hcu_state !== 2'b00 || stall_cnt !== 16'd5 || flush_cnt !== 16'd4) begin errors++; $display("[TB] FAIL pri_counters got=%0b/%0d/%0d exp=00/5/4", hcu_state, stall_cnt, flush_cnt); end
        tick();
    endtask

    task automatic test_no_forwarding();
        idle_inputs();
        nrst = 1'b0;
        #1;
        @(negedge clk);
        nrst = 1'b1;
        memwb_rd = 5'd3; memwb_rd_valid = 1'b1; id_rs1 = 5'd3; id_rs1_used = 1'b1;
        ex_rs1 = 5'd3; ex_rs2 = 5'd3;
        #2;
        checks++; if (a_pc_write !== 1'b0 || a_idex_flush !== 1'b1) begin errors++; $display("[TB] FAIL nofwd_stall got=%0b%0b exp=01", a_pc_write, a_idex_flush); end
        checks++; if (a_fwd_a_sel !== 2'b00 || a_fwd_b_sel !== 2'b00) begin errors++; $display("[TB] FAIL nofwd_sel got=%0b/%0b exp=00/00", a_fwd_a_sel, a_fwd_b_sel); end
        checks++; if (pc_write !== 1'b1 || fwd_a_sel !== 2'b10) begin errors++; $display("[TB] FAIL fwd_inst_no_stall got=%0b/%0b exp=1/10", pc_write, fwd_a_sel); end
    endtask

    task automatic test_saturate_and_reset();
        idle_inputs();
        nrst = 1'b0;
        #1;
        @(negedge clk);
        nrst = 1'b1;
        memwb_rd = 5'd3; memwb_rd_valid = 1'b1; id_rs1 = 5'd3; id_rs1_used = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        idle_inputs();
        checks++; if (a_stall_cnt !== 2'd3) begin errors++; $display("[TB] FAIL sat_stall_cnt got=%0d exp=3", a_stall_cnt); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL sat_main_stall_cnt got=%0d exp=0", stall_cnt); end
        redirect = 1'b1; imem_busy = 1'b1;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (a_hcu_state !== 2'b10 || a_flush_cnt !== 2'd1) begin errors++; $display("[TB] FAIL sat_kill got=%0b/%0d exp=10/1", a_hcu_state, a_flush_cnt); end
        #1;
        nrst = 1'b0;
        #1;
        checks++; if (a_hcu_state !== 2'b00 || a_stall_cnt !== 2'd0 || a_flush_cnt !== 2'd0) begin errors++; $display("[TB] FAIL kill_reset_state got=%0b/%0d/%0d exp=00/0/0", a_hcu_state, a_stall_cnt, a_flush_cnt); end
        checks++; if (a_pc_write !== 1'b0 || a_ifid_flush !== 1'b0) begin errors++; $display("[TB] FAIL kill_reset_outputs got=%0b%0b exp=00", a_pc_write, a_ifid_flush); end
        imem_busy = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        tick();
        checks++; if (a_hcu_state !== 2'b00 || a_pc_write !== 1'b1) begin errors++; $display("[TB] FAIL kill_reset_release got=%0b/%0b exp=00/1", a_hcu_state, a_pc_write); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_dmem_wait();
        test_redirect_kill();
        test_back_to_back_redirect();
        test_forwarding();
        test_priority();
        test_no_forwarding();
        test_saturate_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] timeout");
    end

endmodule
